axil_reg_slave: RTL and testbench

//  AXI4-lite responder terminating a master port (e.g. m_axil_* of a CDC bridge) into a bank of
//  NUM_REGS DATA_WIDTH-bit control/status registers. Single clock domain; one write and one read

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_reg_slave_wr_join.sv | 55 +++++
 rtl/axil_reg_slave.sv | 162 ++++++++++++++++
 tb/tb_axil_reg_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-lite response codes and a byte-strobe merge helper
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Widest data bus the merge helper handles; callers zero-extend and truncate.
    localparam int AXIL_MAX_DW = 256;
    localparam int AXIL_MAX_SW = AXIL_MAX_DW / 8;

    function automatic logic [AXIL_MAX_DW-1:0] strb_merge(
        input logic [AXIL_MAX_DW-1:0] old_word,
        input logic [AXIL_MAX_DW-1:0] new_word,
        input logic [AXIL_MAX_SW-1:0] strb
    );
        logic [AXIL_MAX_DW-1:0] m;
        for (int i = 0; i < AXIL_MAX_SW; i++)
            m[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        return m;
    endfunction

endpackage

// File: rtl/axil_reg_slave_wr_join.sv
// axil_reg_slave_wr_join: holds AW and W beats independently and flags when both are present
module axil_reg_slave_wr_join #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [STRB_WIDTH-1:0] w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic                  b_busy,
    output logic [ADDR_WIDTH-1:0] addr_q,
    output logic [DATA_WIDTH-1:0] data_q,
    output logic [STRB_WIDTH-1:0] strb_q,
    output logic                  commit
);

    logic aw_full;
    logic w_full;

    // While a response is pending nothing new is accepted, so only one write is ever in flight.
    assign aw_ready = ~aw_full & ~b_busy;
    assign w_ready  = ~w_full & ~b_busy;
    assign commit   = aw_full & w_full;

    // Capture each channel on its own handshake; both holding flags drop on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_valid && aw_ready) begin
                aw_full <= 1'b1;
                addr_q  <= aw_addr;
            end
            if (w_valid && w_ready) begin
                w_full <= 1'b1;
                data_q <= w_data;
                strb_q <= w_strb;
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-lite register bank; AXIL_REG_SLAVE_RD_PIPE_EN adds a read-data stage
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [ADDR_WIDTH-1:0]               addr_q;
    logic [DATA_WIDTH-1:0]               data_q;
    logic [STRB_WIDTH-1:0]               strb_q;
    logic                                commit;
    logic [IDX_W-1:0]                    aw_idx;
    logic [IDX_W-1:0]                    ar_idx;
    logic                                aw_hit;
    logic                                ar_hit;
    logic                                ar_hs;
    logic [DATA_WIDTH-1:0]               rd_word;
    logic                                unused;

    assign unused  = ^{s_axil_awprot, s_axil_arprot, addr_q[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
    assign reg_out = regs;
    assign aw_idx  = addr_q[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx  = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign aw_hit  = 32'(aw_idx) < NUM_REGS;
    assign ar_hit  = 32'(ar_idx) < NUM_REGS;
    assign ar_hs   = s_axil_arvalid & s_axil_arready;

    axil_reg_slave_wr_join #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_wr_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .aw_addr  (s_axil_awaddr),
        .aw_valid (s_axil_awvalid),
        .aw_ready (s_axil_awready),
        .w_data   (s_axil_wdata),
        .w_strb   (s_axil_wstrb),
        .w_valid  (s_axil_wvalid),
        .w_ready  (s_axil_wready),
        .b_busy   (s_axil_bvalid),
        .addr_q   (addr_q),
        .data_q   (data_q),
        .strb_q   (strb_q),
        .commit   (commit)
    );

    // Commit a joined write into the addressed register and raise the B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs          <= '0;
            reg_wr        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= AXI_RESP_OKAY;
        end else begin
            reg_wr <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && 32'(aw_idx) == i) begin
                    regs[i]   <= DATA_WIDTH'(strb_merge(AXIL_MAX_DW'(regs[i]), AXIL_MAX_DW'(data_q),
                                                        AXIL_MAX_SW'(strb_q)));
                    reg_wr[i] <= 1'b1;
                end
            end
            if (commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= aw_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Read mux; out-of-range indices match no register and yield zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (32'(ar_idx) == i) rd_word = regs[i];
    end

`ifdef AXIL_REG_SLAVE_RD_PIPE_EN
    logic                  p_valid;
    logic [DATA_WIDTH-1:0] p_data;
    logic [1:0]            p_resp;

    assign s_axil_arready = ~s_axil_rvalid & ~p_valid;

    // Sample the register on AR, then forward through one extra stage to the R channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid       <= 1'b0;
            p_data        <= '0;
            p_resp        <= AXI_RESP_OKAY;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= AXI_RESP_OKAY;
        end else begin
            p_valid <= ar_hs;
            if (ar_hs) begin
                p_data <= rd_word;
                p_resp <= ar_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if (p_valid) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= p_data;
                s_axil_rresp  <= p_resp;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end
`else
    assign s_axil_arready = ~s_axil_rvalid;

    // Sample the register on AR and hold the R beat until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= AXI_RESP_OKAY;
        end else if (ar_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= ar_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed checks of the AXI4-lite register bank
module tb_axil_reg_slave;

`ifdef AXIL_REG_SLAVE_RD_PIPE_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [15:0]  araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr;

    logic [31:0]  m [16];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    axil_reg_slave dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (3'b000),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (3'b000),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .reg_out        (reg_out),
        .reg_wr         (reg_wr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_reg%0d", tag, i), 64'(reg_out[i*32 +: 32]), 64'(m[i]));
    endtask

    task automatic send_aw(input logic [15:0] a);
        int t = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && t < 20) begin tick(); t++; end
        check("aw_wait", 64'(t < 20), 64'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && t < 20) begin tick(); t++; end
        check("w_wait", 64'(t < 20), 64'd1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic send_both(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        while (!(awready && wready) && t < 20) begin tick(); t++; end
        check("aww_wait", 64'(t < 20), 64'd1);
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] resp, input logic [15:0] wr, input int hold);
        int t = 0;
        while (!bvalid && t < 20) begin tick(); t++; end
        check({tag, "_bwait"}, 64'(t < 20), 64'd1);
        check({tag, "_bresp"}, 64'(bresp), 64'(resp));
        check({tag, "_regwr"}, 64'(reg_wr), 64'(wr));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_bhold"}, 64'({bvalid, bresp, awready, wready}), 64'({1'b1, resp, 2'b00}));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_bclr"}, 64'(bvalid), 64'd0);
    endtask

    task automatic get_r(input string tag, input logic [31:0] d, input logic [1:0] resp);
        int t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        check({tag, "_rlat"}, 64'(t), 64'(RD_LAT));
        check({tag, "_rdata"}, 64'(rdata), 64'(d));
        check({tag, "_rresp"}, 64'(rresp), 64'(resp));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, "_rclr"}, 64'(rvalid), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
        int t = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!arready && t < 20) begin tick(); t++; end
        check({tag, "_arwait"}, 64'(t < 20), 64'd1);
        tick();
        arvalid = 1'b0;
        get_r(tag, d, resp);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m[i] = '0;
        #12;
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_resp", 64'({bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_regwr", 64'(reg_wr), 64'd0);
        check("rst_ready", 64'({awready, wready, arready}), 64'b111);
        check_regs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: AW and W in the same cycle
        awaddr = 16'h0008; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        check("t1_ready", 64'({awready, wready}), 64'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_b_early", 64'(bvalid), 64'd0);
        tick();
        check("t1_bvalid", 64'(bvalid), 64'd1);
        check("t1_bresp", 64'(bresp), 64'd0);
        check("t1_regwr", 64'(reg_wr), 64'h0004);
        m[2] = 32'hDEADBEEF;
        check_regs("t1");
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t1_bclr", 64'(bvalid), 64'd0);
        check("t1_wrclr", 64'(reg_wr), 64'd0);

        // 2: W three cycles ahead of AW, partial strobes
        send_w(32'h11223344, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_b", 64'(bvalid), 64'd0);
            check("t2_wready", 64'(wready), 64'd0);
            if (i < 2) tick();
        end
        send_aw(16'h0008);
        wait_b("t2", 2'b00, 16'h0004, 0);
        m[2] = 32'hDE22BE44;
        check_regs("t2");
        rd("t2rd", 16'h0008, 32'hDE22BE44, 2'b00);

        // 3: index 16 is past the bank
        send_both(16'h0040, 32'hFFFFFFFF, 4'hF);
        wait_b("t3", 2'b10, 16'h0000, 0);
        check_regs("t3");
        rd("t3rd", 16'h0040, 32'h0, 2'b10);

        // 4: B back-pressure, then a second write
        send_both(16'h000C, 32'hA5A5A5A5, 4'hF);
        wait_b("t4a", 2'b00, 16'h0008, 10);
        m[3] = 32'hA5A5A5A5;
        send_both(16'h000C, 32'h00001234, 4'b0011);
        wait_b("t4b", 2'b00, 16'h0008, 0);
        m[3] = 32'hA5A51234;
        check_regs("t4");

        // 5: write commit and AR to reg1 on the same edge
        awaddr = 16'h0004; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 16'h0004; arvalid = 1'b1;
        check("t5_arready", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        check("t5_bvalid", 64'(bvalid), 64'd1);
        check("t5_regwr", 64'(reg_wr), 64'h0002);
        get_r("t5old", 32'h0, 2'b00);
        wait_b("t5", 2'b00, 16'h0000, 0);
        m[1] = 32'h5;
        rd("t5new", 16'h0004, 32'h5, 2'b00);

        // 6: reset with only AW held
        send_aw(16'h0000);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m[i] = '0;
        check("t6_bvalid", 64'(bvalid), 64'd0);
        check_regs("t6rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_w(32'h00000077, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_b", 64'(bvalid), 64'd0);
            tick();
        end
        check_regs("t6mid");
        send_aw(16'h0000);
        wait_b("t6", 2'b00, 16'h0001, 0);
        m[0] = 32'h77;
        check_regs("t6");
        rd("t6rd", 16'h0002, 32'h77, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
